// File: rtl/frame_receiver_if.sv
// Pixel-stream input and frame-buffer write bus of the Bayer frame receiver.
// The source drives the stream; the receiver drives the write command.
interface frame_receiver_if #(
  parameter int Naddr = 17
);
  logic             SOF;
  logic             EOL;
  logic             DVAL;
  logic [7:0]       pixel;
  logic             wr_en;
  logic [Naddr-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [1:0]       bayer_phase;

  modport master (
    output SOF, EOL, DVAL, pixel,
    input  wr_en, wr_addr, wr_data, bayer_phase
  );

  modport slave (
    input  SOF, EOL, DVAL, pixel,
    output wr_en, wr_addr, wr_data, bayer_phase
  );
endinterface

// File: rtl/frame_receiver.sv
// Bayer stream sink: rebuilds (x,y) from SOF/EOL/DVAL and issues frame-buffer
// writes, with line-length / frame-structure checks and a completed-frame count.
//
// state | meaning
// IDLE  | waiting for SOF, beats dropped
// RECV  | receiving a frame, every beat written
// DROP  | line overran Nrows, beats discarded until EOL
module frame_receiver #(
  parameter int Nrows = 349,
  parameter int Ncol  = 349
) (
  input  logic            clk,
  input  logic            rst,
  frame_receiver_if.slave pix_if,
  output logic            frame_done,
  output logic [15:0]     frame_cnt,
  output logic            busy,
  output logic            len_err,
  output logic            sof_err
);
  localparam int Naddr = (Nrows * Ncol > 1) ? $clog2(Nrows * Ncol) : 1;
  localparam int XW    = (Nrows > 1) ? $clog2(Nrows) : 1;
  localparam int YW    = (Ncol > 1) ? $clog2(Ncol) : 1;

  localparam logic [XW-1:0]    X_LAST    = XW'(Nrows - 1);
  localparam logic [YW-1:0]    Y_LAST    = YW'(Ncol - 1);
  localparam logic [Naddr-1:0] LINE_STEP = Naddr'(Nrows);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [Naddr-1:0] line_base_q, line_base_d;
  logic             wr_en_q, wr_en_d;
  logic [Naddr-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [1:0]       bayer_phase_q, bayer_phase_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             busy_q, busy_d;
  logic             len_err_q, len_err_d;
  logic             sof_err_q, sof_err_d;

  logic [XW-1:0]    pos_x;
  logic [YW-1:0]    pos_y;
  logic [Naddr-1:0] pos_base;
  logic             active;
  logic             restart;
  logic             dropping;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      line_base_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      bayer_phase_q <= '0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      busy_q        <= 1'b0;
      len_err_q     <= 1'b0;
      sof_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_base_q   <= line_base_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      bayer_phase_q <= bayer_phase_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      busy_q        <= busy_d;
      len_err_q     <= len_err_d;
      sof_err_q     <= sof_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    line_base_d   = line_base_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    bayer_phase_d = bayer_phase_q;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    len_err_d     = len_err_q;
    sof_err_d     = sof_err_q;
    pos_x         = x_q;
    pos_y         = y_q;
    pos_base      = line_base_q;
    active        = 1'b0;
    restart       = 1'b0;
    dropping      = 1'b0;

    // SOF is resolved first so that a same-beat EOL sees the restarted position.
    if (pix_if.DVAL) begin
      if (pix_if.SOF) begin
        active   = 1'b1;
        restart  = (state_q != IDLE);
        pos_x    = '0;
        pos_y    = '0;
        pos_base = '0;
        state_d  = RECV;
        if (restart) begin
          sof_err_d = 1'b1;
        end else begin
          len_err_d = 1'b0;
          sof_err_d = 1'b0;
        end
      end else if (state_q != IDLE) begin
        active   = 1'b1;
        dropping = (state_q == DROP);
      end
    end

    if (active) begin
      x_d         = pos_x;
      y_d         = pos_y;
      line_base_d = pos_base;
      if (!dropping) begin
        wr_en_d       = 1'b1;
        wr_addr_d     = pos_base + Naddr'(pos_x);
        wr_data_d     = pix_if.pixel;
        bayer_phase_d = {pos_y[0], pos_x[0]};
      end
      if (pix_if.EOL) begin
        if (!dropping && (pos_x != X_LAST)) len_err_d = 1'b1;
        state_d     = RECV;
        x_d         = '0;
        y_d         = pos_y + 1'b1;
        line_base_d = pos_base + LINE_STEP;
        if (pos_y == Y_LAST) begin
          y_d         = '0;
          line_base_d = '0;
          // A restart beat never completes a frame; it just keeps receiving.
          if (!restart) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
          end
        end
      end else if (!dropping) begin
        if (pos_x == X_LAST) begin
          len_err_d = 1'b1;
          state_d   = DROP;
        end else begin
          x_d = pos_x + 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign pix_if.wr_en       = wr_en_q;
  assign pix_if.wr_addr     = wr_addr_q;
  assign pix_if.wr_data     = wr_data_q;
  assign pix_if.bayer_phase = bayer_phase_q;
  assign frame_done         = frame_done_q;
  assign frame_cnt          = frame_cnt_q;
  assign busy               = busy_q;
  assign len_err            = len_err_q;
  assign sof_err            = sof_err_q;
endmodule

// File: tb/tb_frame_receiver.sv
// Bench for frame_receiver on a 4x3 frame: scripted test-plan sequences, a
// vector table for the short-line case, then random beats against a reference model.
module tb_frame_receiver;
  localparam int NROWS = 4;
  localparam int NCOL  = 3;
  localparam int NADDR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        busy;
  logic        len_err;
  logic        sof_err;

  frame_receiver_if #(.Naddr(NADDR)) bus ();

  frame_receiver #(.Nrows(NROWS), .Ncol(NCOL)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_if     (bus),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .busy       (busy),
    .len_err    (len_err),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
    int phase;
  } wr_t;
  wr_t wr_q[$];
  int  done_seen;

  // reference model: position in the frame and expected registered outputs
  bit m_in, m_drop;
  int m_x, m_y;
  bit e_wr_en, e_done, e_busy, e_len, e_sof;
  int e_addr, e_data, e_phase, e_cnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_in = 0; m_drop = 0; m_x = 0; m_y = 0;
    e_wr_en = 0; e_done = 0; e_busy = 0; e_len = 0; e_sof = 0;
    e_addr = 0; e_data = 0; e_phase = 0; e_cnt = 0;
  endfunction

  function automatic void model_step(bit sof, bit eol, bit dval, logic [7:0] pix);
    bit restart;
    restart = 0;
    e_wr_en = 0;
    e_done  = 0;
    if (!dval) return;
    if (sof) begin
      restart = m_in;
      if (m_in) e_sof = 1;
      else begin e_len = 0; e_sof = 0; end
      m_in = 1; m_drop = 0; m_x = 0; m_y = 0;
    end else if (!m_in) begin
      return;
    end
    if (!m_drop) begin
      e_wr_en = 1;
      e_addr  = m_y * NROWS + m_x;
      e_data  = pix;
      e_phase = (m_y % 2) * 2 + (m_x % 2);
    end
    if (eol) begin
      if (!m_drop && m_x != NROWS - 1) e_len = 1;
      m_drop = 0;
      m_x = 0;
      m_y = m_y + 1;
      if (m_y == NCOL) begin
        m_y = 0;
        if (!restart) begin
          e_done = 1;
          e_cnt  = (e_cnt + 1) % 65536;
          m_in   = 0;
        end
      end
    end else if (!m_drop) begin
      if (m_x == NROWS - 1) begin
        e_len  = 1;
        m_drop = 1;
      end else begin
        m_x = m_x + 1;
      end
    end
    e_busy = m_in;
  endfunction

  task automatic compare_all();
    chk("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(e_cnt));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("len_err", 32'(len_err), 32'(e_len));
    chk("sof_err", 32'(sof_err), 32'(e_sof));
    if (e_wr_en) begin
      chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
      chk("wr_data", 32'(bus.wr_data), 32'(e_data));
      chk("bayer_phase", 32'(bus.bayer_phase), 32'(e_phase));
    end
  endtask

  task automatic beat(bit sof, bit eol, bit dval, logic [7:0] pix);
    bus.SOF   = sof;
    bus.EOL   = eol;
    bus.DVAL  = dval;
    bus.pixel = pix;
    @(posedge clk);
    #1;
    model_step(sof, eol, dval, pix);
    compare_all();
    if (frame_done) done_seen++;
    if (bus.wr_en) wr_q.push_back('{int'(bus.wr_addr), int'(bus.wr_data), int'(bus.bayer_phase)});
  endtask

  task automatic do_reset();
    bus.DVAL = 0;
    rst = 0;
    #1;
    model_reset();
    compare_all();
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_phase", 32'(bus.bayer_phase), 32'd0);
    @(posedge clk);
    #1;
    rst = 1;
    wr_q.delete();
    done_seen = 0;
  endtask

  task automatic clean_frame(bit gaps, int pix_base);
    for (int i = 0; i < NROWS * NCOL; i++) begin
      beat(i == 0, (i % NROWS) == NROWS - 1, 1'b1, 8'(pix_base + i));
      if (gaps) beat(1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
    end
  endtask

  task automatic chk_linear_writes(string name, int n);
    chk({name, "_nwr"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++)
      chk({name, "_addr"}, 32'(wr_q[i].addr), 32'(i));
  endtask

  typedef struct {
    bit         sof;
    bit         eol;
    logic [7:0] pix;
    int         exp_addr;
    bit         exp_len;
    bit         exp_done;
  } vec_t;
  vec_t tbl[11];

  initial begin
    bus.SOF = 0; bus.EOL = 0; bus.DVAL = 0; bus.pixel = 0;
    done_seen = 0;
    model_reset();

    // short line 0 (EOL on 3rd pixel), then two full lines
    for (int i = 0; i < 11; i++) begin
      tbl[i].sof      = (i == 0);
      tbl[i].eol      = (i == 2 || i == 6 || i == 10);
      tbl[i].pix      = 8'(8'h40 + i);
      tbl[i].exp_addr = (i < 3) ? i : i + 1;
      tbl[i].exp_len  = (i >= 2);
      tbl[i].exp_done = (i == 10);
    end

    // test 1: clean frame
    do_reset();
    clean_frame(1'b0, 0);
    chk_linear_writes("t1", 12);
    for (int i = 0; i < wr_q.size(); i++) begin
      chk("t1_data", 32'(wr_q[i].data), 32'(i));
      chk("t1_phase", 32'(wr_q[i].phase), 32'(((i / 4) % 2) * 2 + (i % 2)));
    end
    chk("t1_done", 32'(done_seen), 32'd1);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_len", 32'(len_err), 32'd0);
    chk("t1_sof", 32'(sof_err), 32'd0);

    // test 2: DVAL low every other cycle
    do_reset();
    clean_frame(1'b1, 8'h80);
    chk_linear_writes("t2", 12);
    chk("t2_done", 32'(done_seen), 32'd1);
    chk("t2_cnt", 32'(frame_cnt), 32'd1);

    // test 3: table-driven short line
    do_reset();
    for (int i = 0; i < 11; i++) begin
      beat(tbl[i].sof, tbl[i].eol, 1'b1, tbl[i].pix);
      chk("t3_wr_en", 32'(bus.wr_en), 32'd1);
      chk("t3_addr", 32'(bus.wr_addr), 32'(tbl[i].exp_addr));
      chk("t3_data", 32'(bus.wr_data), 32'(tbl[i].pix));
      chk("t3_len", 32'(len_err), 32'(tbl[i].exp_len));
      chk("t3_done", 32'(frame_done), 32'(tbl[i].exp_done));
    end

    // test 4: long line 1 (6 pixels)
    do_reset();
    for (int i = 0; i < 4; i++) beat(i == 0, i == 3, 1'b1, 8'(i));
    for (int i = 0; i < 6; i++) beat(1'b0, i == 5, 1'b1, 8'(8'h10 + i));
    chk("t4_len", 32'(len_err), 32'd1);
    for (int i = 0; i < 4; i++) beat(1'b0, i == 3, 1'b1, 8'(8'h20 + i));
    chk_linear_writes("t4", 12);
    chk("t4_data_line2", 32'(wr_q[8].data), 32'h20);
    chk("t4_done", 32'(done_seen), 32'd1);

    // test 5: SOF on the 7th beat restarts the frame
    do_reset();
    for (int i = 0; i < 6; i++) beat(i == 0, i == 3, 1'b1, 8'(i));
    beat(1'b1, 1'b0, 1'b1, 8'hA5);
    chk("t5_sof", 32'(sof_err), 32'd1);
    chk("t5_addr", 32'(bus.wr_addr), 32'd0);
    chk("t5_data", 32'(bus.wr_data), 32'hA5);
    for (int i = 1; i < 12; i++) beat(1'b0, (i % 4) == 3, 1'b1, 8'(i));
    chk("t5_cnt", 32'(frame_cnt), 32'd1);
    chk("t5_done", 32'(done_seen), 32'd1);
    chk("t5_nwr", 32'(wr_q.size()), 32'd18);

    // test 6: reset mid-frame, orphan beats, then a clean frame
    do_reset();
    for (int i = 0; i < 5; i++) beat(i == 0, i == 3, 1'b1, 8'(i));
    do_reset();
    for (int i = 0; i < 4; i++) beat(1'b0, i == 3, 1'b1, 8'(i));
    chk("t6_orphan_nwr", 32'(wr_q.size()), 32'd0);
    clean_frame(1'b0, 8'h30);
    chk("t6_cnt", 32'(frame_cnt), 32'd1);
    chk("t6_done", 32'(done_seen), 32'd1);

    // random stream against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) == 0) do_reset();
      beat($urandom_range(99) < 4, $urandom_range(99) < 25,
           $urandom_range(99) < 75, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
- Sink end of the Bayer pixel stream (SOF / EOL / DVAL / 8-bit pixel) used across the demosaicing datapath.
- Reconstructs frame geometry from the stream and produces frame-buffer write commands: address, data and Bayer phase.
- Checks line length and frame structure, and counts completed frames.
- Sits between the pixel source and the frame memory feeding the demosaicing core.

Parameters:
- Nrows, 349: pixels per line.
- Ncol, 349: lines per frame.
- Naddr, clogb2(Nrows*Ncol): frame-buffer address width (localparam).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- SOF  in  1  qualified by DVAL; marks the first pixel of a frame.
- EOL  in  1  qualified by DVAL; marks the last pixel of a line.
- DVAL  in  1  pixel valid; no beat when low.
- pixel  in  8  pixel data.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  Naddr  write address, y*Nrows + x.
- wr_data  out  8  registered pixel.
- bayer_phase  out  2  {y[0], x[0]} of the written pixel.
- frame_done  out  1  one-cycle pulse on frame completion.
- frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0.
- busy  out  1  high while in RECV.
- len_err  out  1  sticky line-length error.
- sof_err  out  1  sticky SOF-inside-frame error.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; x, y, line_base and all outputs = 0.
- Beat = cycle with DVAL=1. Cycles with DVAL=0 change nothing except clearing wr_en and frame_done.
- All outputs are registered. wr_en/wr_addr/wr_data/bayer_phase appear 1 cycle after the beat.
- Address is kept incrementally: line_base advances by Nrows per line, wr_addr = line_base + x. No multiplier.
- IDLE:
  - Beat without SOF: dropped, no write.
  - Beat with SOF: clear len_err and sof_err; write at addr 0, phase 00; go to RECV with x=1, y=0, line_base=0.
- RECV, normal beat: write at (x,y), then x++.
- RECV, beat with EOL:
  - Write the pixel first.
  - If x != Nrows-1, set len_err.
  - Then x=0, y++, line_base += Nrows.
  - If y == Ncol-1: frame_done=1 for one cycle with the last write, frame_cnt++, go to IDLE.
- RECV, beat with x == Nrows-1 and no EOL:
  - Write the pixel and set len_err.
  - Enter drop mode: following beats are not written until EOL.
  - The EOL beat itself is not written; it advances the line as above, including frame completion.
- RECV, beat with SOF:
  - Set sof_err; len_err is kept.
  - Restart the frame: this pixel is written at addr 0, x=1, y=0, line_base=0.
  - frame_cnt is unchanged.
- SOF and EOL on the same beat (only valid when Nrows=1): apply SOF handling first, then EOL handling.
- frame_done never coincides with a restart. SOF takes priority over frame completion on the same beat.
- Reset asserted mid-frame: everything is cleared immediately. Pixels after reset release are ignored until the next SOF.

Test Plan (Nrows=4, Ncol=3):
1. Clean frame, pixels 0x00..0x0B with continuous DVAL:
   - wr_addr 0..11 and wr_data 0x00..0x0B, each 1 cycle after its beat.
   - bayer_phase sequence 00,01,00,01 / 10,11,10,11 / 00,...
   - frame_done pulses with addr 11; frame_cnt=1; len_err=0, sof_err=0.
2. Same frame with DVAL low on every other cycle:
   - Identical address/data sequence; wr_en low during gaps; frame_done exactly once.
3. Short line, EOL on the 3rd pixel of line 0:
   - len_err=1; next pixel written at addr 4; frame completes at addr 11.
4. Long line, 6 pixels on line 1 with EOL on the 6th:
   - Addrs 4..7 written, then len_err=1; the 5th and 6th pixels are not written.
   - Line 2 starts at addr 8.
5. SOF on the 7th beat (line 1, x=2):
   - sof_err=1; that pixel written at addr 0; 11 more beats complete the frame.
   - frame_cnt=1, not 2.
6. rst low for 1 cycle after 5 pixels:
   - All outputs 0 immediately.
   - 4 beats without SOF produce no writes.
   - A following SOF frame completes normally with frame_cnt=1.
